gba_sound_fifo_ctrl: RTL

- Direct-sound FIFO controller for GBA channels A and B.
- Each channel consumes 8-bit PCM samples from a word FIFO, paced by the overflow tick of timer 0 or timer 1.
- Schedules DMA refill requests when the FIFO runs low.
- Sits between the timer block (timer0_tick / timer1_tick), the DMA controller, and the sound mixer.

---
 rtl/gba_sound_fifo_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/gba_sound_fifo_ctrl.sv
// Direct-sound FIFO controller for GBA channels A and B.
// Each channel buffers 32-bit words, emits one signed PCM byte per selected timer
// overflow (byte 0 first), and requests DMA refills when the FIFO runs low.
module gba_sound_fifo_ctrl #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned REFILL_LEVEL = 4,
  parameter int unsigned BURST        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gb_on,
  input  logic        timer0_tick,
  input  logic        timer1_tick,
  input  logic        cfg_tsel_a,
  input  logic        cfg_tsel_b,
  input  logic        cfg_rst_a,
  input  logic        cfg_rst_b,
  input  logic        wr_a,
  input  logic        wr_b,
  input  logic [31:0] wr_data,
  input  logic        dma_ack_a,
  input  logic        dma_ack_b,
  output logic        dma_req_a,
  output logic        dma_req_b,
  output logic [7:0]  sample_a,
  output logic [7:0]  sample_b,
  output logic        sample_stb_a,
  output logic        sample_stb_b,
  output logic        ovf_a,
  output logic        ovf_b,
  output logic        unf_a,
  output logic        unf_b
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned XW = $clog2(BURST) + 1;

  typedef enum logic [1:0] {StIdle, StReq, StXfer} dma_state_e;

  // Channel 0 = A, channel 1 = B.
  logic [1:0] tsel, cfg_rst, wr, dma_ack;
  logic [1:0] dma_req, stb, ovf, unf;
  logic [7:0] sample [2];

  assign tsel    = {cfg_tsel_b, cfg_tsel_a};
  assign cfg_rst = {cfg_rst_b, cfg_rst_a};
  assign wr      = {wr_b, wr_a};
  assign dma_ack = {dma_ack_b, dma_ack_a};

  assign dma_req_a    = dma_req[0];
  assign dma_req_b    = dma_req[1];
  assign sample_a     = sample[0];
  assign sample_b     = sample[1];
  assign sample_stb_a = stb[0];
  assign sample_stb_b = stb[1];
  assign ovf_a        = ovf[0];
  assign ovf_b        = ovf[1];
  assign unf_a        = unf[0];
  assign unf_b        = unf[1];

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [1:0]    byte_idx_q;
    logic [7:0]    sample_q;
    logic          stb_q, ovf_q, unf_q, dma_req_q;
    logic [XW-1:0] xfer_cnt_q;
    dma_state_e    state_q;

    logic       clr, tick, not_empty, full, pop, push, low;
    logic [7:0] head_byte;

    // Per-channel strobes; a pop frees a slot so a push at full still lands.
    always_comb begin
      clr       = cfg_rst[c] | ~gb_on;
      tick      = tsel[c] ? timer1_tick : timer0_tick;
      not_empty = (count_q != '0);
      full      = (count_q == CW'(DEPTH));
      pop       = tick && not_empty && (byte_idx_q == 2'd3);
      push      = wr[c] && (!full || pop);
      low       = (count_q <= CW'(REFILL_LEVEL));
      head_byte = mem_q[rd_ptr_q][{byte_idx_q, 3'b000} +: 8];
    end

    // Word storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
      if (push && !clr) begin
        mem_q[wr_ptr_q] <= wr_data;
      end
    end

    // Pointers, count, sample output and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        byte_idx_q <= '0;
        sample_q   <= '0;
        stb_q      <= 1'b0;
        ovf_q      <= 1'b0;
        unf_q      <= 1'b0;
      end else if (clr) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        byte_idx_q <= '0;
        sample_q   <= '0;
        stb_q      <= 1'b0;
        ovf_q      <= 1'b0;
        unf_q      <= 1'b0;
      end else begin
        stb_q <= 1'b0;
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop) begin
          count_q <= count_q + 1'b1;
        end else if (pop && !push) begin
          count_q <= count_q - 1'b1;
        end
        if (tick) begin
          if (not_empty) begin
            sample_q   <= head_byte;
            stb_q      <= 1'b1;
            byte_idx_q <= byte_idx_q + 2'd1;
          end else begin
            unf_q <= 1'b1;
          end
        end
        if (wr[c] && full && !pop) ovf_q <= 1'b1;
      end
    end

    // DMA refill handshake: request when low, then count BURST writes after the grant.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q    <= StIdle;
        dma_req_q  <= 1'b0;
        xfer_cnt_q <= '0;
      end else if (clr) begin
        state_q    <= StIdle;
        dma_req_q  <= 1'b0;
        xfer_cnt_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (gb_on && low) begin
              state_q   <= StReq;
              dma_req_q <= 1'b1;
            end
          end
          StReq: begin
            if (dma_ack[c]) begin
              state_q    <= StXfer;
              dma_req_q  <= 1'b0;
              xfer_cnt_q <= '0;
            end
          end
          StXfer: begin
            // Dropped writes still count toward the burst.
            if (wr[c]) begin
              if (xfer_cnt_q == XW'(BURST - 1)) begin
                state_q    <= StIdle;
                xfer_cnt_q <= '0;
              end else begin
                xfer_cnt_q <= xfer_cnt_q + 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end

    assign dma_req[c] = dma_req_q;
    assign stb[c]     = stb_q;
    assign ovf[c]     = ovf_q;
    assign unf[c]     = unf_q;
    assign sample[c]  = sample_q;
  end

endmodule
